// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates branch conditions at execute and
// trains a bimodal predictor of saturating counters read at fetch.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   pred_pc           fetch PC to look up
//   pred_taken        predicted direction (combinational)
//   res_valid         branch resolving this cycle
//   res_pc            PC of resolving branch
//   res_funct3        branch funct3
//   res_rs1, res_rs2  compare operands
//   res_target        taken target
//   res_pred_taken    prediction carried with the branch
//   out_valid         registered result valid (one cycle)
//   out_taken         resolved direction
//   out_mispredict    resolved direction differs from prediction
//   out_redirect_pc   taken ? target : pc+4
//   out_illegal       funct3 is not a branch encoding
//   perf_branches     legal branches resolved
//   perf_mispredicts  legal mispredicts
module branch_resolve_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_BITS    = 2,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   pred_pc,
   output logic              pred_taken,
   input  logic              res_valid,
   input  logic [XLEN-1:0]   res_pc,
   input  logic [2:0]        res_funct3,
   input  logic [XLEN-1:0]   res_rs1,
   input  logic [XLEN-1:0]   res_rs2,
   input  logic [XLEN-1:0]   res_target,
   input  logic              res_pred_taken,
   output logic              out_valid,
   output logic              out_taken,
   output logic              out_mispredict,
   output logic [XLEN-1:0]   out_redirect_pc,
   output logic              out_illegal,
   output logic [PERF_W-1:0] perf_branches,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam int IW = $clog2(BHT_ENTRIES);

   // Weakly not-taken; collapses to 0 for a 1-bit counter.
   localparam logic [CNT_BITS-1:0] CNT_INIT =
      CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

   logic [CNT_BITS-1:0] cnt_q [BHT_ENTRIES];
   logic [CNT_BITS-1:0] cnt_d;

   logic [IW-1:0] pred_idx;
   logic [IW-1:0] res_idx;

   logic          cond_eq;
   logic          cond_lt;
   logic          cond_ltu;
   logic          cond_base;
   logic          legal;
   logic          taken;
   logic          mispredict;
   logic          train;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] redirect_pc;

   logic              out_valid_q;
   logic              out_taken_q;
   logic              out_mispredict_q;
   logic [XLEN-1:0]   out_redirect_pc_q;
   logic              out_illegal_q;
   logic [PERF_W-1:0] perf_branches_q;
   logic [PERF_W-1:0] perf_mispredicts_q;

   // Only the index bits of either PC feed the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[XLEN-1:IW+2], pred_pc[1:0],
                             res_pc[XLEN-1:IW+2], res_pc[1:0]};

   assign pred_idx = pred_pc[IW+1:2];
   assign res_idx  = res_pc[IW+1:2];

   // Reads the registered table, so a same-cycle train is not bypassed.
   assign pred_taken = cnt_q[pred_idx][CNT_BITS-1];

   assign cond_eq  = (res_rs1 == res_rs2);
   assign cond_lt  = ($signed(res_rs1) < $signed(res_rs2));
   assign cond_ltu = (res_rs1 < res_rs2);

   // funct3[2:1] picks the comparison, funct3[0] inverts it.
   always_comb begin
      cond_base = 1'b0;
      legal     = 1'b1;
      unique case (1'b1)
         (res_funct3[2:1] == 2'b00): cond_base = cond_eq;
         (res_funct3[2:1] == 2'b10): cond_base = cond_lt;
         (res_funct3[2:1] == 2'b11): cond_base = cond_ltu;
         default:                    legal     = 1'b0;
      endcase
   end

   assign taken       = legal & (cond_base ^ res_funct3[0]);
   assign mispredict  = legal & (taken ^ res_pred_taken);
   assign train       = res_valid & legal;
   assign seq_pc      = res_pc + XLEN'(4);
   assign redirect_pc = taken ? res_target : seq_pc;

   always_comb begin
      cnt_d = cnt_q[res_idx];
      if (taken) begin
         if (cnt_q[res_idx] != CNT_MAX) begin
            cnt_d = cnt_q[res_idx] + 1'b1;
         end
      end else begin
         if (cnt_q[res_idx] != CNT_ZERO) begin
            cnt_d = cnt_q[res_idx] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
      end else if (train) begin
         cnt_q[res_idx] <= cnt_d;
      end
   end

   // Result fields hold their last value when nothing resolves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q       <= 1'b0;
         out_taken_q       <= 1'b0;
         out_mispredict_q  <= 1'b0;
         out_redirect_pc_q <= '0;
         out_illegal_q     <= 1'b0;
      end else begin
         out_valid_q <= res_valid;
         if (res_valid) begin
            out_taken_q       <= taken;
            out_mispredict_q  <= mispredict;
            out_redirect_pc_q <= redirect_pc;
            out_illegal_q     <= ~legal;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches_q    <= '0;
         perf_mispredicts_q <= '0;
      end else if (train) begin
         perf_branches_q <= perf_branches_q + PERF_W'(1);
         if (mispredict) begin
            perf_mispredicts_q <= perf_mispredicts_q + PERF_W'(1);
         end
      end
   end

   assign out_valid        = out_valid_q;
   assign out_taken        = out_taken_q;
   assign out_mispredict   = out_mispredict_q;
   assign out_redirect_pc  = out_redirect_pc_q;
   assign out_illegal      = out_illegal_q;
   assign perf_branches    = perf_branches_q;
   assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
// Expected values are hand-derived from the predictor/compare rules.
module tb_branch_resolve_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic        res_valid;
   logic [31:0] res_pc;
   logic [2:0]  res_funct3;
   logic [31:0] res_rs1;
   logic [31:0] res_rs2;
   logic [31:0] res_target;
   logic        res_pred_taken;
   logic        out_valid;
   logic        out_taken;
   logic        out_mispredict;
   logic [31:0] out_redirect_pc;
   logic        out_illegal;
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;

   int n_cmp;
   int n_bad;

   branch_resolve_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pred_pc          (pred_pc),
      .pred_taken       (pred_taken),
      .res_valid        (res_valid),
      .res_pc           (res_pc),
      .res_funct3       (res_funct3),
      .res_rs1          (res_rs1),
      .res_rs2          (res_rs2),
      .res_target       (res_target),
      .res_pred_taken   (res_pred_taken),
      .out_valid        (out_valid),
      .out_taken        (out_taken),
      .out_mispredict   (out_mispredict),
      .out_redirect_pc  (out_redirect_pc),
      .out_illegal      (out_illegal),
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] tgt, input logic pt);
      res_valid      = 1'b1;
      res_pc         = pc;
      res_funct3     = f3;
      res_rs1        = a;
      res_rs2        = b;
      res_target     = tgt;
      res_pred_taken = pt;
      @(posedge clk);
      #1;
      res_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic t,
                          input logic m, input logic [31:0] rd,
                          input logic il);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".taken"}, {31'd0, out_taken}, {31'd0, t});
      chk({tag, ".mis"}, {31'd0, out_mispredict}, {31'd0, m});
      chk({tag, ".redir"}, out_redirect_pc, rd);
      chk({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, il});
   endtask

   task automatic chk_perf(input string tag, input logic [31:0] br,
                           input logic [31:0] mp);
      chk({tag, ".pbr"}, perf_branches, br);
      chk({tag, ".pmis"}, perf_mispredicts, mp);
   endtask

   task automatic chk_pred(input string tag, input logic [31:0] pc,
                           input logic exp);
      pred_pc = pc;
      #1;
      chk(tag, {31'd0, pred_taken}, {31'd0, exp});
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
      chk_perf(tag, 32'd0, 32'd0);
      for (int i = 0; i < 64; i++) begin
         pred_pc = i * 4;
         #1;
         chk({tag, ".pred"}, {31'd0, pred_taken}, 32'd0);
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_bad          = 0;
      rst_n          = 1'b0;
      pred_pc        = '0;
      res_valid      = 1'b0;
      res_pc         = '0;
      res_funct3     = '0;
      res_rs1        = '0;
      res_rs2        = '0;
      res_target     = '0;
      res_pred_taken = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("rst0");
      chk_out("rst0", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      #2 rst_n = 1'b1;

      // BEQ idx0, predicted not-taken, resolves taken: cnt 1->2
      resolve(32'h100, 3'b000, 32'd7, 32'd7, 32'h180, 1'b0);
      chk_out("beq1", 1'b1, 1'b1, 1'b1, 32'h180, 1'b0);
      chk_perf("beq1", 32'd1, 32'd1);
      chk_pred("beq1.pred", 32'h100, 1'b1);

      // cnt 2->3
      resolve(32'h100, 3'b000, 32'd7, 32'd7, 32'h180, 1'b0);
      chk_out("beq2", 1'b1, 1'b1, 1'b1, 32'h180, 1'b0);
      chk_perf("beq2", 32'd2, 32'd2);
      chk_pred("beq2.pred", 32'h100, 1'b1);

      // Signed: -1 < 1
      resolve(32'h204, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0);
      chk_out("blt", 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
      chk_perf("blt", 32'd3, 32'd3);
      // Unsigned: 0xFFFFFFFF !< 1
      resolve(32'h208, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0);
      chk_out("bltu", 1'b1, 1'b0, 1'b0, 32'h20C, 1'b0);
      chk_perf("bltu", 32'd4, 32'd3);
      resolve(32'h20C, 3'b101, 32'd5, 32'd5, 32'h400, 1'b1);
      chk_out("bge", 1'b1, 1'b1, 1'b0, 32'h400, 1'b0);
      chk_perf("bge", 32'd5, 32'd3);
      chk_pred("blt.pred", 32'h204, 1'b1);
      chk_pred("bltu.pred", 32'h208, 1'b0);
      // BGEU: 1 >= 0xFFFFFFFF unsigned is false
      resolve(32'h214, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h500, 1'b0);
      chk_out("bgeu", 1'b1, 1'b0, 1'b0, 32'h218, 1'b0);
      chk_perf("bgeu", 32'd6, 32'd3);

      // Saturation at idx4: four back-to-back taken BNE, cnt 1->3
      for (int k = 0; k < 4; k++) begin
         resolve(32'h110, 3'b001, 32'd1, 32'd2, 32'h600, 1'b1);
         chk_out("sat.t", 1'b1, 1'b1, 1'b0, 32'h600, 1'b0);
      end
      chk_perf("sat.t", 32'd10, 32'd3);
      // one not-taken: 3->2, still predicts taken
      resolve(32'h110, 3'b001, 32'd9, 32'd9, 32'h600, 1'b1);
      chk_out("sat.nt", 1'b1, 1'b0, 1'b1, 32'h114, 1'b0);
      chk_perf("sat.nt", 32'd11, 32'd4);
      chk_pred("sat.pred2", 32'h110, 1'b1);
      // 2->1
      resolve(32'h110, 3'b001, 32'd9, 32'd9, 32'h600, 1'b0);
      chk_pred("sat.pred1", 32'h110, 1'b0);
      chk_perf("sat.nt2", 32'd12, 32'd4);

      // Illegal funct3 at idx4 (cnt 1): no training, no perf
      resolve(32'h110, 3'b010, 32'd3, 32'd3, 32'h700, 1'b1);
      chk_out("ill2", 1'b1, 1'b0, 1'b0, 32'h114, 1'b1);
      chk_perf("ill2", 32'd12, 32'd4);
      resolve(32'h110, 3'b011, 32'd3, 32'd4, 32'h700, 1'b0);
      chk_out("ill3", 1'b1, 1'b0, 1'b0, 32'h114, 1'b1);
      chk_perf("ill3", 32'd12, 32'd4);
      chk_pred("ill.pred", 32'h110, 1'b0);
      // One taken: 1->2 only if the illegal ops left the counter alone
      resolve(32'h110, 3'b000, 32'd3, 32'd3, 32'h700, 1'b0);
      chk_pred("ill.after", 32'h110, 1'b1);
      chk_perf("ill.after", 32'd13, 32'd5);

      // Idle cycle: valid drops, fields hold
      @(posedge clk);
      #1;
      chk_out("idle", 1'b0, 1'b1, 1'b1, 32'h700, 1'b0);

      // pc+4 wraps
      resolve(32'hFFFF_FFFC, 3'b000, 32'd1, 32'd2, 32'h800, 1'b0);
      chk_out("wrap", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk_perf("wrap", 32'd14, 32'd5);

      // Same-index predict and train (idx6, cnt 1)
      pred_pc        = 32'h118;
      res_valid      = 1'b1;
      res_pc         = 32'h118;
      res_funct3     = 3'b000;
      res_rs1        = 32'd4;
      res_rs2        = 32'd4;
      res_target     = 32'h900;
      res_pred_taken = 1'b0;
      #1;
      chk("same.old", {31'd0, pred_taken}, 32'd0);
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      chk("same.new", {31'd0, pred_taken}, 32'd1);

      // Mid-stream async reset with a branch in flight
      resolve(32'h300, 3'b000, 32'd1, 32'd1, 32'hA00, 1'b0);
      res_valid  = 1'b1;
      res_pc     = 32'h304;
      res_funct3 = 3'b000;
      res_rs1    = 32'd2;
      res_rs2    = 32'd2;
      res_target = 32'hB00;
      #2 rst_n = 1'b0;
      #1;
      chk_reset_state("rst1");
      @(posedge clk);
      #1;
      chk("rst1.drop", {31'd0, out_valid}, 32'd0);

      // First edge after release is accepted
      res_pred_taken = 1'b1;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      chk_out("post", 1'b1, 1'b1, 1'b0, 32'hB00, 1'b0);
      chk_perf("post", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      chk("post.idle", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
